// File: rtl/pipe_pkg.sv
// Shared encodings for the RV32I pipeline: opcodes, branch/LSU codes,
// write-back select, and the MEM-stage handshake states.
package pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef enum logic [1:0] {
        WB_PC4 = 2'b00,
        WB_ALU = 2'b01,
        WB_LD  = 2'b10
    } wb_sel_e;

    // Load size/sign codes; stores reuse the low two bits
    typedef enum logic [2:0] {
        LSU_LB  = 3'b000,
        LSU_LH  = 3'b001,
        LSU_LW  = 3'b010,
        LSU_LBU = 3'b100,
        LSU_LHU = 3'b101
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_B = 2'b00,
        ST_H = 2'b01,
        ST_W = 2'b10
    } st_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for data memory: store replication/mask and
// load extraction with sign or zero extension.
module lsu_align
    import pipe_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  bmask,
    output logic [31:0] ld_data
);

    logic [31:0] rshift;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        wdata = st_data;
        bmask = 4'b0000;
        case (size[1:0])
            ST_B: begin
                wdata = {4{st_data[7:0]}};
                bmask = 4'b0001 << addr_lo;
            end
            ST_H: begin
                wdata = {2{st_data[15:0]}};
                case (addr_lo)
                    2'b00:   bmask = 4'b0011;
                    2'b10:   bmask = 4'b1100;
                    default: bmask = 4'b0000;
                endcase
            end
            ST_W: begin
                wdata = st_data;
                bmask = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
            end
            default: begin
                wdata = st_data;
                bmask = 4'b0000;
            end
        endcase
    end

    assign rshift = rdata >> {addr_lo, 3'b000};

    always_comb begin
        ld_data = rdata;
        case (size)
            LSU_LB:  ld_data = {{24{rshift[7]}}, rshift[7:0]};
            LSU_LH:  ld_data = {{16{rshift[15]}}, rshift[15:0]};
            LSU_LBU: ld_data = {24'h000000, rshift[7:0]};
            LSU_LHU: ld_data = {16'h0000, rshift[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// MEM stage of the RV32I pipeline: branch resolution, the data-memory
// req/ack handshake with pipeline stall, and the MEM/WB register.
module memory_cycle #(
    parameter int unsigned DMEM_ADDR_W = 32,
    parameter logic [31:0] NOP_INST    = pipe_pkg::NOP_INST
) (
    input  logic                   i_memory_clk,
    input  logic                   i_memory_reset,
    input  logic [31:0]            i_memory_pc,
    input  logic [31:0]            i_memory_inst,
    input  logic                   i_memory_insn_vld,
    input  logic                   i_memory_ctrl,
    input  logic                   i_memory_br_equal,
    input  logic                   i_memory_br_less,
    input  logic [31:0]            i_memory_alu_data,
    input  logic [31:0]            i_memory_rs2_data,
    input  logic                   i_memory_lsu_wren,
    input  logic [2:0]             i_memory_slt_sl,
    input  logic [1:0]             i_memory_wb_sel,
    input  logic                   i_memory_rd_wren,
    output logic                   o_dmem_req,
    output logic                   o_dmem_we,
    output logic [DMEM_ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]            o_dmem_wdata,
    output logic [3:0]             o_dmem_bmask,
    input  logic                   i_dmem_ack,
    input  logic [31:0]            i_dmem_rdata,
    output logic                   o_memory_stall,
    output logic                   o_memory_flush,
    output logic [31:0]            o_memory_pc_redirect,
    output logic [31:0]            o_memory_fwd_alu_data,
    output logic [31:0]            o_memory_pc_wb,
    output logic [31:0]            o_memory_alu_data_wb,
    output logic [31:0]            o_memory_ld_data_wb,
    output logic [31:0]            o_memory_inst_wb,
    output logic [1:0]             o_memory_wb_sel_wb,
    output logic                   o_memory_rd_wren_wb,
    output logic                   o_memory_insn_vld_wb
);

    import pipe_pkg::*;

    mem_state_e  state_q;
    mem_state_e  state_d;
    logic        access;
    logic        req;
    logic        stall;
    logic        taken;
    logic        flush;
    logic [31:0] ld_data;

    assign access = i_memory_insn_vld & (i_memory_lsu_wren | (i_memory_wb_sel == WB_LD));

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_memory_clk or posedge i_memory_reset) begin
        if (i_memory_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request is raised in the same cycle the access arrives; a same-cycle ack skips WAIT.
    // Reset gates the request so a held EX/MEM access cannot re-issue while reset is high.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (!i_dmem_ack) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (i_dmem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_memory_reset) begin
            req = 1'b0;
        end
        stall = req & ~i_dmem_ack;
    end

    always_comb begin
        taken = 1'b0;
        case (i_memory_inst[6:0])
            OP_BRANCH: begin
                case (i_memory_inst[14:12])
                    F3_BEQ:  taken = i_memory_br_equal;
                    F3_BNE:  taken = ~i_memory_br_equal;
                    F3_BLT:  taken = i_memory_br_less;
                    F3_BGE:  taken = ~i_memory_br_less;
                    F3_BLTU: taken = i_memory_br_less;
                    F3_BGEU: taken = ~i_memory_br_less;
                    default: taken = 1'b0;
                endcase
            end
            OP_JAL, OP_JALR: taken = 1'b1;
            default:         taken = 1'b0;
        endcase
    end

    assign flush = ~i_memory_reset & i_memory_ctrl & i_memory_insn_vld & ~stall & taken;

    assign o_memory_flush        = flush;
    assign o_memory_pc_redirect  = flush ? {i_memory_alu_data[31:1], 1'b0} : 32'h0000_0000;
    assign o_memory_stall        = stall;
    assign o_memory_fwd_alu_data = i_memory_alu_data;

    assign o_dmem_req  = req;
    assign o_dmem_we   = req & i_memory_lsu_wren;
    assign o_dmem_addr = DMEM_ADDR_W'({i_memory_alu_data[31:2], 2'b00});

    lsu_align u_lsu_align (
        .addr_lo (i_memory_alu_data[1:0]),
        .size    (i_memory_slt_sl),
        .st_data (i_memory_rs2_data),
        .rdata   (i_dmem_rdata),
        .wdata   (o_dmem_wdata),
        .bmask   (o_dmem_bmask),
        .ld_data (ld_data)
    );

    // While stalled the register takes a bubble so WB never sees a half-finished access.
    always_ff @(posedge i_memory_clk or posedge i_memory_reset) begin
        if (i_memory_reset) begin
            o_memory_pc_wb       <= 32'h0000_0000;
            o_memory_alu_data_wb <= 32'h0000_0000;
            o_memory_ld_data_wb  <= 32'h0000_0000;
            o_memory_inst_wb     <= NOP_INST;
            o_memory_wb_sel_wb   <= WB_PC4;
            o_memory_rd_wren_wb  <= 1'b0;
            o_memory_insn_vld_wb <= 1'b0;
        end else begin
            o_memory_pc_wb       <= i_memory_pc;
            o_memory_alu_data_wb <= i_memory_alu_data;
            o_memory_ld_data_wb  <= ld_data;
            o_memory_wb_sel_wb   <= i_memory_wb_sel;
            if (stall) begin
                o_memory_inst_wb     <= NOP_INST;
                o_memory_rd_wren_wb  <= 1'b0;
                o_memory_insn_vld_wb <= 1'b0;
            end else begin
                o_memory_inst_wb     <= i_memory_inst;
                o_memory_rd_wren_wb  <= i_memory_rd_wren;
                o_memory_insn_vld_wb <= i_memory_insn_vld;
            end
        end
    end

endmodule
